// File: rtl/msk_piso_reader_if.sv
// Masked word-in / beat-out handshake bundle; slave is the reader, master is the producer/consumer side.
interface msk_piso_reader_if #(
    parameter int d     = 2,
    parameter int count = 4,
    parameter int chunk = 1
);
    logic                   in_valid;
    logic                   in_ready;
    logic [count*d-1:0]     in;
    logic                   out_valid;
    logic                   out_ready;
    logic [chunk*d-1:0]     out;
    logic                   out_last;

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, out_last
    );

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, out_last
    );
endinterface

// File: rtl/msk_piso_reader.sv
// Masked PISO: captures count shared elements, emits chunk elements per beat, shares never combined.
// Latency: first beat one cycle after load; one beat per cycle sustained, back-to-back words without bubble.
// Backpressure: out_ready low freezes data/counter; in_ready only in IDLE or on an accepted last beat.
module msk_piso_reader #(
    parameter int d     = 2,
    parameter int count = 4,
    parameter int chunk = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    msk_piso_reader_if.slave    bus
);
    localparam int BEATS = count / chunk;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int W     = count * d;
    localparam int SH    = chunk * d;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_q, state_n;
    logic [W-1:0]   data_q, data_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic           last;
    logic           load;
    logic           accept;

    // Control is derived from state and counter only, never from share values.
    assign last          = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign bus.out_valid = (state_q == SHIFT);
    assign bus.out_last  = last;
    assign bus.in_ready  = (state_q == IDLE) || (last && bus.out_ready);
    assign bus.out       = data_q[SH-1:0];
    assign load          = bus.in_valid && bus.in_ready;
    assign accept        = bus.out_valid && bus.out_ready;

    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        cnt_n   = cnt_q;
        if (load) begin
            state_n = SHIFT;
            data_n  = bus.in;
            cnt_n   = '0;
        end else if (accept && last) begin
            state_n = IDLE;
            data_n  = '0;
            cnt_n   = '0;
        end else if (accept) begin
            // Whole-element shift keeps every share in its own lane.
            data_n  = data_q >> SH;
            cnt_n   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            cnt_q   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_msk_piso_reader.sv
// Directed bench: chunk=1 instance for beat order/backpressure/back-to-back, chunk=count instance for BEATS=1.
module tb_msk_piso_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    msk_piso_reader_if #(.d(2), .count(4), .chunk(1)) a_if ();
    msk_piso_reader_if #(.d(2), .count(4), .chunk(4)) b_if ();

    msk_piso_reader #(.d(2), .count(4), .chunk(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    msk_piso_reader #(.d(2), .count(4), .chunk(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] o, input logic v, input logic l);
        chk({tag, "_out"}, 32'(a_if.out), 32'(o));
        chk({tag, "_vld"}, 32'(a_if.out_valid), 32'(v));
        chk({tag, "_last"}, 32'(a_if.out_last), 32'(l));
    endtask

    initial begin
        a_if.in_valid = 1'b0; a_if.in = '0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in = '0; b_if.out_ready = 1'b1;
        #2;
        chk_a("rst", 2'b00, 1'b0, 1'b0);
        chk("rst_in_rdy", 32'(a_if.in_ready), 32'd1);
        chk("rst_b_vld", 32'(b_if.out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk_a("idle", 2'b00, 1'b0, 1'b0);

        // Plain word, out_ready high: 00,01,10,11.
        a_if.in_valid = 1'b1; a_if.in = 8'b11_10_01_00;
        #1 chk("w1_in_rdy", 32'(a_if.in_ready), 32'd1);
        step();
        a_if.in_valid = 1'b0; a_if.in = '0;
        chk_a("w1_b0", 2'b00, 1'b1, 1'b0);
        step(); chk_a("w1_b1", 2'b01, 1'b1, 1'b0);
        step(); chk_a("w1_b2", 2'b10, 1'b1, 1'b0);
        step(); chk_a("w1_b3", 2'b11, 1'b1, 1'b1);
        step(); chk_a("w1_idle", 2'b00, 1'b0, 1'b0);
        chk("w1_idle_rdy", 32'(a_if.in_ready), 32'd1);

        // Backpressure at beat 1 with an ignored load attempt, then back-to-back word.
        a_if.in_valid = 1'b1; a_if.in = 8'b11_10_01_00;
        step();
        a_if.in_valid = 1'b0;
        chk_a("bp_b0", 2'b00, 1'b1, 1'b0);
        step();
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1; a_if.in = 8'h5A;
        #1 chk("ign_in_rdy", 32'(a_if.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk_a("bp_hold", 2'b01, 1'b1, 1'b0);
            step();
            a_if.in_valid = 1'b0; a_if.in = '0;
        end
        a_if.out_ready = 1'b1;
        chk_a("bp_b1", 2'b01, 1'b1, 1'b0);
        step(); chk_a("bp_b2", 2'b10, 1'b1, 1'b0);
        step(); chk_a("bp_b3", 2'b11, 1'b1, 1'b1);
        a_if.in_valid = 1'b1; a_if.in = 8'b00_11_00_11;
        #1 chk("b2b_in_rdy", 32'(a_if.in_ready), 32'd1);
        step();
        a_if.in_valid = 1'b0; a_if.in = '0;
        chk_a("b2b_b0", 2'b11, 1'b1, 1'b0);
        step(); chk_a("b2b_b1", 2'b00, 1'b1, 1'b0);
        step(); chk_a("b2b_b2", 2'b11, 1'b1, 1'b0);
        step(); chk_a("b2b_b3", 2'b00, 1'b1, 1'b1);
        step(); chk_a("b2b_idle", 2'b00, 1'b0, 1'b0);

        // Reset in the middle of a word.
        a_if.in_valid = 1'b1; a_if.in = 8'b11_10_01_00;
        step();
        a_if.in_valid = 1'b0;
        step(); chk_a("mr_b1", 2'b01, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1 chk_a("mr_rst", 2'b00, 1'b0, 1'b0);
        chk("mr_in_rdy", 32'(a_if.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step(); chk_a("mr_post0", 2'b00, 1'b0, 1'b0);
        step(); chk_a("mr_post1", 2'b00, 1'b0, 1'b0);

        // BEATS=1: one word per cycle, each beat is last.
        b_if.in_valid = 1'b1; b_if.in = 8'hC6;
        #1 chk("b_w0_rdy", 32'(b_if.in_ready), 32'd1);
        step();
        b_if.in = 8'h3B;
        #1 chk("b_w0_out", 32'(b_if.out), 32'hC6);
        chk("b_w0_last", 32'(b_if.out_last), 32'd1);
        chk("b_w1_rdy", 32'(b_if.in_ready), 32'd1);
        step();
        b_if.in = 8'h71;
        #1 chk("b_w1_out", 32'(b_if.out), 32'h3B);
        chk("b_w1_vld", 32'(b_if.out_valid), 32'd1);
        step();
        b_if.in_valid = 1'b0; b_if.in = '0;
        #1 chk("b_w2_out", 32'(b_if.out), 32'h71);
        chk("b_w2_last", 32'(b_if.out_last), 32'd1);
        step();
        chk("b_idle_vld", 32'(b_if.out_valid), 32'd0);
        b_if.in_valid = 1'b1; b_if.in = 8'h9D; b_if.out_ready = 1'b0;
        step();
        b_if.in_valid = 1'b1; b_if.in = 8'h11;
        #1 chk("b_bp_out", 32'(b_if.out), 32'h9D);
        chk("b_bp_rdy", 32'(b_if.in_ready), 32'd0);
        step();
        b_if.in_valid = 1'b0;
        chk("b_bp_hold", 32'(b_if.out), 32'h9D);
        b_if.out_ready = 1'b1;
        step();
        chk("b_bp_idle", 32'(b_if.out_valid), 32'd0);
        chk("b_bp_clr", 32'(b_if.out), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/msk_piso_reader.md
Name: msk_piso_reader

Overview:
- Masked parallel-in/serial-out read-out buffer for masked state.
- Captures a full masked word of `count` shared elements (d shares each) in one handshake.
- Streams the word out in beats of `chunk` shared elements over a valid/ready interface.
- Sits at the consumer end of masked state held in enable-registers; unloads that state to a narrow masked bus without ever combining shares.

Parameters:
- d, 2, number of shares per masked element (d >= 1).
- count, 4, number of masked elements per parallel word.
- chunk, 1, masked elements per output beat. Constraints: count % chunk == 0 and chunk >= 1. Derived BEATS = count/chunk.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  parallel masked word available.
- in_ready  output  1  block accepts a word this cycle.
- in  input  count*d  masked word; element i occupies bits [i*d +: d], share j at bit i*d+j.
- out_valid  output  1  beat present on out.
- out_ready  input  1  consumer accepts beat.
- out  output  chunk*d  masked beat, same element/share layout as in.
- out_last  output  1  high with the final beat of a word.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Data register cleared to 0, beat counter 0, state IDLE.
  - in_ready=1, out_valid=0, out_last=0, out=0.
- Storage: one count*d-bit register plus a beat counter of width max(1, clog2(BEATS)).
- Masking-safety rules:
  - out is driven directly from the low chunk*d bits of the data register, with no logic after the register.
  - Shifting moves whole elements only (by chunk*d bits), so share j of any element only ever moves to share-j positions.
  - No XOR/AND across shares anywhere. Control signals never depend on share values.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: load in, counter <= 0, go to SHIFT.
  - The first beat is visible on out one cycle after the load (latency 1).
- State SHIFT:
  - out_valid=1, out = elements [chunk*k .. chunk*k+chunk-1] of the loaded word at beat k (low elements first).
  - out_last = (counter == BEATS-1).
  - out_valid & !out_ready: register, counter and out hold stable (no change until accepted).
  - Beat accepted, not last: register shifts right by chunk*d bits (vacated top filled with 0), counter++.
- Last-beat handling:
  - in_ready = IDLE or (SHIFT and out_last and out_ready).
  - Last beat accepted, in_valid=0: go to IDLE, register cleared to 0.
  - Last beat accepted and in_valid=1 in the same cycle: new word loaded, counter <= 0, stay in SHIFT (back-to-back, no bubble).
- BEATS=1 (chunk==count): every beat is last; out_last=1 whenever out_valid=1.
- in_valid while in SHIFT and not on an accepted last beat: ignored (in_ready=0), and the word is not captured.
- in_valid is not required to be held after acceptance; the in-side holds per standard valid/ready rules.
- Reset asserted mid-word: word discarded immediately. Outputs take reset values asynchronously; no partial beats after rst_n rises.
- Throughput: one beat per cycle with out_ready held high; a full word every BEATS cycles sustained.

Test Plan:
- Reset then idle: rst_n=0 mid-SHIFT -> out_valid=0, in_ready=1, out=0 immediately. After release, nothing emitted until in_valid.
- d=2, count=4, chunk=1, in=8'b11_10_01_00, out_ready=1 -> beats out=00,01,10,11 on consecutive cycles starting 1 cycle after load. out_last only on 11. Then IDLE, in_ready=1.
- Backpressure: same word, out_ready low for 3 cycles at beat 1 -> out=01, out_valid=1, out_last=0 held for 3 cycles. Next beats 10,11 follow with no skipped or duplicated beat.
- Back-to-back: second word 8'b00_11_00_11 with in_valid=1 during the accepted last beat of the first word -> in_ready=1 that cycle. Next cycle out=11 (element 0 of new word) with no idle cycle.
- Ignored load: in_valid=1 during beat 1 of a word -> in_ready=0, the current word completes unchanged, and the ignored word never appears.
- chunk=count=4 (BEATS=1), d=2 -> each accepted word yields one beat out=in with out_last=1. Sustains one word per cycle with in_valid and out_ready held high.
